// File: rtl/serial_pkg.sv
// Types and constants shared by the serial transmitter, the complementer and their benches.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/word_hold_buf.sv
// Single-entry word buffer: valid/ready on the write side, a take strobe on the read side.
module word_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             take,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    // A take is only issued while full and an accept only while empty, so they never coincide.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (in_valid && !full_q) begin
            data_d = in_data;
            full_d = 1'b1;
        end else if (take && full_q) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign in_ready  = !full_q;
    assign hold_data = data_q;
    assign hold_full = full_q;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with a word-start strobe aligned to bit 0.
//
// state | meaning
// IDLE  | no word on the serial line; ser_bit held at 0
// SHIFT | a word is on the line; cnt is the index of the bit currently on ser_bit
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_start,
    output logic             ser_active,
    output logic             word_done
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             start_q, start_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             last_bit;
    logic             load;

    word_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .take      (load),
        .hold_data (hold_data),
        .hold_full (hold_full)
    );

    assign last_bit = (cnt_q == LAST);
    // Loading on the last-bit edge is what keeps back-to-back words gap-free.
    assign load     = hold_full && ((state_q == IDLE) || last_bit);

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        bit_d    = 1'b0;
        start_d  = 1'b0;
        active_d = 1'b0;
        done_d   = 1'b0;
        if (load) begin
            state_d  = SHIFT;
            sh_d     = hold_data;
            cnt_d    = '0;
            bit_d    = hold_data[0];
            start_d  = 1'b1;
            active_d = 1'b1;
        end else if (state_q == SHIFT) begin
            if (!last_bit) begin
                cnt_d    = cnt_q + 1'b1;
                sh_d     = sh_q >> 1;
                bit_d    = sh_q[1];
                active_d = 1'b1;
                done_d   = (cnt_d == LAST);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            cnt_q    <= '0;
            bit_q    <= 1'b0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            start_q  <= start_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign ser_bit    = bit_q;
    assign ser_start  = start_q;
    assign ser_active = active_q;
    assign word_done  = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: an 8-bit and a 4-bit instance checked against a bit-level scoreboard.
module tb_serial_word_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] in_data8 = '0;
    logic       in_valid8 = 1'b0;
    logic       in_ready8, ser_bit8, ser_start8, ser_active8, word_done8;

    logic [3:0] in_data4 = '0;
    logic       in_valid4 = 1'b0;
    logic       in_ready4, ser_bit4, ser_start4, ser_active4, word_done4;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid8),
        .in_ready(in_ready8), .ser_bit(ser_bit8), .ser_start(ser_start8),
        .ser_active(ser_active8), .word_done(word_done8)
    );

    serial_word_tx #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .ser_bit(ser_bit4), .ser_start(ser_start4),
        .ser_active(ser_active4), .word_done(word_done4)
    );

    typedef struct {
        bit b;
        bit s;
        bit d;
    } exp_t;

    // seq lists the bits in transmission order: seq[0] is the first bit on the line
    typedef struct {
        logic [7:0] data;
        logic [0:7] seq;
    } vec_t;

    exp_t q8[$];
    exp_t q4[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n) begin
            if (ser_active8) begin
                if (q8.size() == 0) begin
                    check("unexpected_active8", 32'(ser_active8), 32'd0);
                end else begin
                    e = q8.pop_front();
                    check("bit8",   32'(ser_bit8),   32'(e.b));
                    check("start8", 32'(ser_start8), 32'(e.s));
                    check("done8",  32'(word_done8), 32'(e.d));
                end
            end else begin
                check("idle8", 32'({ser_bit8, ser_start8, word_done8}), 32'd0);
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (rst_n) begin
            if (ser_active4) begin
                if (q4.size() == 0) begin
                    check("unexpected_active4", 32'(ser_active4), 32'd0);
                end else begin
                    e = q4.pop_front();
                    check("bit4",   32'(ser_bit4),   32'(e.b));
                    check("start4", 32'(ser_start4), 32'(e.s));
                    check("done4",  32'(word_done4), 32'(e.d));
                end
            end else begin
                check("idle4", 32'({ser_bit4, ser_start4, word_done4}), 32'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid8 still high.
    task automatic send8(input logic [7:0] d, input logic [0:7] seq, output int waits);
        waits = 0;
        in_data8  = d;
        in_valid8 = 1'b1;
        while (!in_ready8 && waits < 64) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready8) begin
            check("accept_timeout8", 32'(in_ready8), 32'd1);
        end else begin
            for (int i = 0; i < 8; i++) q8.push_back('{b: seq[i], s: (i == 0), d: (i == 7)});
        end
        @(negedge clk);
    endtask

    task automatic wait_idle8();
        int t;
        t = 0;
        while ((q8.size() != 0 || ser_active8) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout8", 32'(t < 100), 32'd1);
    endtask

    task automatic run_len8(output int n);
        int t;
        t = 0;
        n = 0;
        while (!ser_active8 && t < 30) begin
            @(negedge clk);
            t++;
        end
        while (ser_active8 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin : stim
        vec_t vecs[6];
        int   w, w3, n;

        vecs[0] = '{8'h35, 8'b1010_1100};
        vecs[1] = '{8'hA5, 8'b1010_0101};
        vecs[2] = '{8'h0F, 8'b1111_0000};
        vecs[3] = '{8'h01, 8'b1000_0000};
        vecs[4] = '{8'h80, 8'b0000_0001};
        vecs[5] = '{8'hFF, 8'b1111_1111};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready8", 32'(in_ready8), 32'd1);
        check("rst_outs8", 32'({ser_bit8, ser_start8, ser_active8, word_done8}), 32'd0);
        check("rst_in_ready4", 32'(in_ready4), 32'd1);
        check("rst_outs4", 32'({ser_bit4, ser_start4, ser_active4, word_done4}), 32'd0);

        // single words, each followed by a return to IDLE
        for (int i = 0; i < 6; i++) begin
            send8(vecs[i].data, vecs[i].seq, w);
            check("lat_ready_low", 32'(in_ready8), 32'd0);
            check("lat_not_yet", 32'(ser_active8), 32'd0);
            in_valid8 = 1'b0;
            @(negedge clk);
            check("lat_start", 32'(ser_start8), 32'd1);
            check("lat_ready_back", 32'(in_ready8), 32'd1);
            wait_idle8();
            @(negedge clk);
        end

        // second word offered while the first shifts: 16 contiguous bits
        fork
            begin
                send8(8'hA5, 8'b1010_0101, w);
                in_valid8 = 1'b0;
                repeat (3) @(negedge clk);
                send8(8'h0F, 8'b1111_0000, w);
                in_valid8 = 1'b0;
            end
            run_len8(n);
        join
        check("b2b_run_len", 32'(n), 32'd16);
        wait_idle8();
        @(negedge clk);

        // in_valid held high across three words
        fork
            begin
                send8(8'h01, 8'b1000_0000, w);
                send8(8'h80, 8'b0000_0001, w);
                send8(8'hFF, 8'b1111_1111, w3);
                in_valid8 = 1'b0;
            end
            run_len8(n);
        join
        check("stream_full_wait", 32'(w3), 32'd7);
        check("stream_run_len", 32'(n), 32'd24);
        wait_idle8();
        @(negedge clk);

        // asynchronous reset in the middle of a word
        send8(8'h35, 8'b1010_1100, w);
        in_valid8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'({ser_bit8, ser_start8, ser_active8, word_done8}), 32'd0);
        check("async_rst_ready", 32'(in_ready8), 32'd1);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send8(8'h02, 8'b0100_0000, w);
        in_valid8 = 1'b0;
        @(negedge clk);
        check("post_rst_start", 32'(ser_start8), 32'd1);
        wait_idle8();

        // 4-bit instance
        @(negedge clk);
        in_data4  = 4'hB;
        in_valid4 = 1'b1;
        check("accept4_ready", 32'(in_ready4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            automatic logic [0:3] seq4 = 4'b1101;
            q4.push_back('{b: seq4[i], s: (i == 0), d: (i == 3)});
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        repeat (8) @(negedge clk);

        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
